muldiv_unit: RTL

- Iterative RV32M multiply/divide execution unit.
- Consumes the two register-file read operands and produces a write-back request: WB_ADDR, WB_DATA and WB_WE, muxed onto A3/WD3/WE3.
- BUSY stalls PC update and other write-back sources while an operation runs.
- Radix-2 shift-add multiply and restoring divide: one iteration per cycle.

---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Purpose : iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide)
// Latency : 34 cycles START edge -> DONE (2 for early-out cases when MULDIV_EARLY_OUT_EN is defined)
// Backpressure: none; START is ignored while busy, except at the edge that ends DONE
//
// Ports: clk/rst_n (async active-low); start/funct3/op_a/op_b/rd_addr request;
//        busy/done status; wb_we/wb_addr/wb_data register-file write-back request.
// Optional feature macro: MULDIV_EARLY_OUT_EN (divide-by-zero, signed overflow and
//        multiply-by-zero skip the iteration phase).
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] op_a,
   input  logic [DATA_WIDTH-1:0] op_b,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  wb_we,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [DATA_WIDTH-1:0] wb_data
);

   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN, S_DONE} state_t;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2:0]          f3_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic [2*W-1:0]      acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [W-1:0]        mag_b;    // multiplicand / divisor magnitude
   logic                a_neg;
   logic                b_neg;
   logic                div0;

   // Load-time decode of the incoming request
   logic                ld_a_sgn, ld_b_sgn, ld_a_neg, ld_b_neg;
   logic [W-1:0]        ld_mag_a, ld_mag_b;
   logic                ld_b_zero, ld_ovf, ld_early;
   logic [2*W-1:0]      ld_acc;
   logic                accept;

   always_comb begin
      ld_a_sgn  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
      ld_b_sgn  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                  (funct3 == 3'b100) || (funct3 == 3'b110);
      ld_a_neg  = ld_a_sgn & op_a[W-1];
      ld_b_neg  = ld_b_sgn & op_b[W-1];
      ld_mag_a  = ld_a_neg ? -op_a : op_a;
      ld_mag_b  = ld_b_neg ? -op_b : op_b;
      ld_b_zero = (op_b == '0);
      ld_ovf    = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(W-1){1'b0}}}) & (op_b == '1);
      ld_acc    = {{W{1'b0}}, ld_mag_a};
      ld_early  = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      // Preload the accumulator with the value the full iteration would have produced,
      // so the FIN stage sign/select logic is shared with the normal path.
      if (ld_b_zero) begin
         ld_early = 1'b1;
         ld_acc   = funct3[2] ? {ld_mag_a, {W{1'b1}}} : '0;
      end else if (ld_ovf) begin
         ld_early = 1'b1;
      end
`else
      ld_early  = ld_early & ld_ovf;
`endif
      // A new request is also taken on the edge that ends DONE (back-to-back issue).
      accept    = start && ((state == S_IDLE) || (state == S_DONE));
   end

   // One iteration step
   logic [W:0]     mul_sum;
   logic [W:0]     div_tmp;
   logic [W:0]     div_trial;
   logic [2*W-1:0] calc_next;

   always_comb begin
      mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_b} : {(W+1){1'b0}});
      // Remainder shifted left with the next dividend bit; fits in W+1 bits since rem < divisor.
      div_tmp   = acc[2*W-1:W-1];
      div_trial = div_tmp - {1'b0, mag_b};
      if (!f3_q[2])
         calc_next = {mul_sum, acc[W-1:1]};
      else if (!div_trial[W])
         calc_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
      else
         calc_next = {div_tmp[W-1:0], acc[W-2:0], 1'b0};
   end

   // Sign correction and result selection
   logic           res_neg;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo, rem, fin_res;

   always_comb begin
      res_neg  = a_neg ^ b_neg;
      prod_fix = res_neg ? -acc : acc;
      quo      = acc[W-1:0];
      rem      = acc[2*W-1:W];
      case (f3_q)
         3'b000:                 fin_res = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*W-1:W];
         // Divide-by-zero returns all ones irrespective of the operand signs.
         3'b100, 3'b101:         fin_res = (res_neg && !div0) ? -quo : quo;
         default:                fin_res = a_neg ? -rem : rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         f3_q    <= '0;
         rd_q    <= '0;
         acc     <= '0;
         mag_b   <= '0;
         a_neg   <= 1'b0;
         b_neg   <= 1'b0;
         div0    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wb_we   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         case (state)
            S_IDLE: ;
            S_CALC: begin
               acc <= calc_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W-1))
                  state <= S_FIN;
            end
            S_FIN: begin
               wb_data <= fin_res;
               wb_addr <= rd_q;
               wb_we   <= (rd_q != '0);
               done    <= 1'b1;
               state   <= S_DONE;
            end
            default: begin
               done  <= 1'b0;
               wb_we <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
         if (accept) begin
            f3_q  <= funct3;
            rd_q  <= rd_addr;
            acc   <= ld_acc;
            mag_b <= ld_mag_b;
            a_neg <= ld_a_neg;
            b_neg <= ld_b_neg;
            div0  <= ld_b_zero;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ld_early ? S_FIN : S_CALC;
         end
      end
   end

endmodule
